// File: rtl/asmd_product_accumulator.sv
// Batch accumulator for a multiplier stream: sums num_terms products, one per rising edge of ready.
// Optional macro ACC_SATURATE_EN clamps the sum to all-ones on carry-out instead of wrapping.
module asmd_product_accumulator #(
    parameter int word_length = 4,
    parameter int num_terms   = 4,
    parameter int acc_width   = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2*word_length-1:0] product,
    input  logic                     ready,
    input  logic                     start,
    output logic [acc_width-1:0]     sum,
    output logic [3:0]               term_count,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [1:0]               fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [3:0] last_term = 4'(num_terms - 1);

    state_t                 state;
    state_t                 state_next;
    logic                   ready_d;
    logic                   rise;
    logic                   clear;
    logic                   accumulate;
    logic [acc_width:0]     product_ext;
    logic [acc_width:0]     sum_ext;
    logic [acc_width-1:0]   sum_next;

    assign rise        = ready & ~ready_d;
    assign product_ext = {{(acc_width + 1 - 2*word_length){1'b0}}, product};
    assign sum_ext     = {1'b0, sum} + product_ext;

`ifdef ACC_SATURATE_EN
    // Once the batch has carried out, keep the sum pinned even if later terms are zero.
    assign sum_next = (overflow || sum_ext[acc_width]) ? {acc_width{1'b1}}
                                                        : sum_ext[acc_width-1:0];
`else
    assign sum_next = sum_ext[acc_width-1:0];
`endif

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        accumulate = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (rise) begin
                    accumulate = 1'b1;
                    if (term_count == last_term) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ready_d resets high so a ready level already present after reset is not a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ready_d    <= 1'b1;
            sum        <= '0;
            term_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state   <= state_next;
            ready_d <= ready;
            if (clear) begin
                sum        <= '0;
                term_count <= '0;
                overflow   <= 1'b0;
            end else if (accumulate) begin
                sum        <= sum_next;
                term_count <= term_count + 4'd1;
                if (sum_ext[acc_width]) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign busy      = (state == COLLECT);
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule
